// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiplier and restoring divider.
// Divider datapath present only when MULDIV_DIV_EN is defined; otherwise divide ops return 0.
`ifndef XLEN
`define XLEN 32
`endif

module muldiv_iter #(
    parameter int XLEN = `XLEN,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_data_1,
    input  logic [XLEN-1:0] i_data_2,
    output logic            o_valid,
    input  logic            i_res_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] ONES = '1;
    localparam logic [XLEN-1:0] MINN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [CNTW-1:0]   cnt_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   opb_q;
    logic [XLEN-1:0]   res_q;
    logic              valid_q;
    logic              ready_q;

    // Operand decode at accept time
    logic            s1_en, s2_en, s1, s2, neg_d;
    logic [XLEN-1:0] mag1, mag2;
    logic            special;
    logic [XLEN-1:0] sp_res;

    always_comb begin
        s1_en = (i_op == 3'b001) || (i_op == 3'b010) ||
                (i_op == 3'b100) || (i_op == 3'b110);
        s2_en = (i_op == 3'b001) || (i_op == 3'b100) ||
                (i_op == 3'b110);
        s1    = s1_en & i_data_1[XLEN-1];
        s2    = s2_en & i_data_2[XLEN-1];
        mag1  = s1 ? -i_data_1 : i_data_1;
        mag2  = s2 ? -i_data_2 : i_data_2;
        neg_d = (i_op == 3'b110) ? s1 : (s1 ^ s2);
    end

`ifdef MULDIV_DIV_EN
    logic dz, ovf;
    always_comb begin
        dz      = (i_data_2 == '0);
        ovf     = (i_data_1 == MINN) && (i_data_2 == ONES) && !i_op[0];
        special = i_op[2] && (dz || ovf);
        if (dz)
            sp_res = i_op[1] ? i_data_1 : ONES;
        else
            sp_res = i_op[1] ? '0 : i_data_1;
    end
`else
    always_comb begin
        special = i_op[2];
        sp_res  = '0;
    end
`endif

    // One iteration of the datapath
    logic [XLEN:0]     sum;
    logic [XLEN-1:0]   mhi, mlo;
    logic [XLEN-1:0]   nhi, nlo;
    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0]   fin;

    always_comb begin
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        mhi    = sum[XLEN:1];
        mlo    = {sum[0], lo_q[XLEN-1:1]};
        prod   = {mhi, mlo};
        prod_f = neg_q ? -prod : prod;
        if (op_q[1:0] == 2'b00)
            fin = prod_f[XLEN-1:0];
        else
            fin = prod_f[2*XLEN-1:XLEN];
        nhi = mhi;
        nlo = mlo;
    end

`ifdef MULDIV_DIV_EN
    logic [XLEN:0]   shl, trial;
    logic [XLEN-1:0] dhi, dlo, dval;

    always_comb begin
        shl   = {hi_q, lo_q[XLEN-1]};
        trial = shl - {1'b0, opb_q};
        dhi   = trial[XLEN] ? shl[XLEN-1:0] : trial[XLEN-1:0];
        dlo   = {lo_q[XLEN-2:0], ~trial[XLEN]};
        dval  = op_q[1] ? dhi : dlo;
    end

    logic [XLEN-1:0] nhi_s, nlo_s, fin_s;
    always_comb begin
        nhi_s = op_q[2] ? dhi : nhi;
        nlo_s = op_q[2] ? dlo : nlo;
        fin_s = op_q[2] ? (neg_q ? -dval : dval) : fin;
    end
`else
    logic [XLEN-1:0] nhi_s, nlo_s, fin_s;
    logic            unused_op;
    always_comb begin
        nhi_s = nhi;
        nlo_s = nlo;
        fin_s = fin;
    end
    assign unused_op = op_q[2];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (i_flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        op_q    <= i_op;
                        neg_q   <= neg_d;
                        ready_q <= 1'b0;
                        if (special) begin
                            res_q   <= sp_res;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            // Divide: lo=dividend, opb=divisor; multiply: lo=multiplier
                            hi_q    <= '0;
                            lo_q    <= i_op[2] ? mag1 : mag2;
                            opb_q   <= i_op[2] ? mag2 : mag1;
                            cnt_q   <= CNTW'(XLEN);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi_q  <= nhi_s;
                    lo_q  <= nlo_s;
                    cnt_q <= cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        res_q   <= fin_s;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (i_res_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_busy   = ~ready_q;
    assign o_result = res_q;

endmodule
